// File: rtl/variable_pkg.sv
// Shared match definitions: player roles, turn states and hit-point helpers
// used by player selection and the turn scheduler.
package variable_pkg;

  localparam logic [1:0] NO_PLAYER = 2'd0;
  localparam logic [1:0] PLAYER_1  = 2'd1;
  localparam logic [1:0] PLAYER_2  = 2'd2;

  typedef enum logic [2:0] {
    WAIT_ROLE    = 3'd0,
    LOCAL_AIM    = 3'd1,
    LOCAL_FLIGHT = 3'd2,
    REPORT       = 3'd3,
    REMOTE_WAIT  = 3'd4,
    GAME_OVER    = 3'd5
  } turn_state_t;

  // Hit points never wrap below zero.
  function automatic logic [2:0] hp_after_hit(input logic [2:0] hp, input logic hit);
    logic [2:0] res;
    if (hit && (hp != 3'd0)) begin
      res = hp - 3'd1;
    end else begin
      res = hp;
    end
    return res;
  endfunction

  function automatic logic [1:0] opponent_of(input logic [1:0] role);
    return (role == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Turn-scheduler boundary: role/fire/projectile/link inputs and the
// aim/throw/report/score outputs.
interface turn_scheduler_if;
  logic [1:0] current_player;
  logic       fire_req;
  logic       throw_done;
  logic       throw_hit;
  logic       remote_turn_done;
  logic       remote_hit;
  logic       throw_start;
  logic       aim_enable;
  logic       turn_done_tx;
  logic       hit_tx;
  logic [2:0] hp_local;
  logic [2:0] hp_remote;
  logic       game_over;
  logic [1:0] winner;

  modport slave (
    input  current_player, fire_req, throw_done, throw_hit, remote_turn_done, remote_hit,
    output throw_start, aim_enable, turn_done_tx, hit_tx, hp_local, hp_remote, game_over, winner
  );

  modport master (
    output current_player, fire_req, throw_done, throw_hit, remote_turn_done, remote_hit,
    input  throw_start, aim_enable, turn_done_tx, hit_tx, hp_local, hp_remote, game_over, winner
  );
endinterface

// File: rtl/turn_scheduler_timer.sv
// Loadable/clearable 30-bit turn counter; tc flags when the count equals
// the compare value supplied by the scheduler.
module turn_timer (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [29:0] load_value,
  input  logic        enable,
  input  logic [29:0] tc_value,
  output logic        tc
);

  logic [29:0] count_r;

  // Counter register: clear has priority over load, load over counting.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      count_r <= 30'd0;
    end else if (clear) begin
      count_r <= 30'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable) begin
      count_r <= count_r + 30'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == tc_value);

endmodule

// File: rtl/turn_scheduler.sv
// Match sequencer for the two-board game: grants local aim/throw turns,
// waits for remote turns, keeps both hit-point counts and declares the winner.
module turn_scheduler
  import variable_pkg::*;
#(
  parameter int AIM_TIMEOUT    = 600_000_000,
  parameter int FLIGHT_TIMEOUT = 180_000_000,
  parameter int HP_INIT        = 3
) (
  input logic             clk60MHz,
  input logic             rst,
  turn_scheduler_if.slave ts
);

  localparam logic [29:0] AIM_TC    = 30'(AIM_TIMEOUT - 1);
  localparam logic [29:0] FLIGHT_TC = 30'(FLIGHT_TIMEOUT - 1);
  localparam logic [2:0]  HP_INIT_V = 3'(HP_INIT);

  turn_state_t state_r, state_s;
  logic [1:0]  role_r, role_s;
  logic        result_r, result_s;
  logic [2:0]  hp_local_r, hp_local_s;
  logic [2:0]  hp_remote_r, hp_remote_s;
  logic [1:0]  winner_r, winner_s;
  logic        fire_s;
  logic        throw_start_r, aim_enable_r, turn_done_tx_r, hit_tx_r, game_over_r;
  logic        tc_s, timer_clear_s, timer_en_s;
  logic [29:0] tc_value_s;

  turn_timer u_timer (
    .clk60MHz   (clk60MHz),
    .rst        (rst),
    .clear      (timer_clear_s),
    .load       (1'b0),
    .load_value (30'd0),
    .enable     (timer_en_s),
    .tc_value   (tc_value_s),
    .tc         (tc_s)
  );

  // Next-state, hit-point and winner logic; fire beats a same-cycle aim timeout.
  always_comb begin
    state_s     = state_r;
    role_s      = role_r;
    result_s    = result_r;
    hp_local_s  = hp_local_r;
    hp_remote_s = hp_remote_r;
    winner_s    = winner_r;
    fire_s      = 1'b0;
    case (state_r)
      WAIT_ROLE: begin
        if (ts.current_player == PLAYER_1) begin
          role_s  = PLAYER_1;
          state_s = LOCAL_AIM;
        end else if (ts.current_player == PLAYER_2) begin
          role_s  = PLAYER_2;
          state_s = REMOTE_WAIT;
        end else begin
          state_s = WAIT_ROLE;
        end
      end
      LOCAL_AIM: begin
        if (ts.fire_req) begin
          fire_s  = 1'b1;
          state_s = LOCAL_FLIGHT;
        end else if (tc_s) begin
          result_s = 1'b0;
          state_s  = REPORT;
        end else begin
          state_s = LOCAL_AIM;
        end
      end
      LOCAL_FLIGHT: begin
        if (ts.throw_done) begin
          result_s = ts.throw_hit;
          state_s  = REPORT;
        end else if (tc_s) begin
          result_s = 1'b0;
          state_s  = REPORT;
        end else begin
          state_s = LOCAL_FLIGHT;
        end
      end
      REPORT: begin
        hp_remote_s = hp_after_hit(hp_remote_r, result_r);
        if (hp_remote_s == 3'd0) begin
          winner_s = role_r;
          state_s  = GAME_OVER;
        end else begin
          state_s = REMOTE_WAIT;
        end
      end
      REMOTE_WAIT: begin
        if (ts.remote_turn_done) begin
          hp_local_s = hp_after_hit(hp_local_r, ts.remote_hit);
          if (hp_local_s == 3'd0) begin
            winner_s = opponent_of(role_r);
            state_s  = GAME_OVER;
          end else begin
            state_s = LOCAL_AIM;
          end
        end else begin
          state_s = REMOTE_WAIT;
        end
      end
      GAME_OVER: begin
        state_s = GAME_OVER;
      end
      default: begin
        state_s = WAIT_ROLE;
      end
    endcase
  end

  assign tc_value_s    = (state_r == LOCAL_AIM) ? AIM_TC : FLIGHT_TC;
  assign timer_en_s    = (state_r == LOCAL_AIM) || (state_r == LOCAL_FLIGHT);
  assign timer_clear_s = (state_s != state_r);

  // State, score and output registers; outputs follow the state being entered.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_r        <= WAIT_ROLE;
      role_r         <= NO_PLAYER;
      result_r       <= 1'b0;
      hp_local_r     <= HP_INIT_V;
      hp_remote_r    <= HP_INIT_V;
      winner_r       <= NO_PLAYER;
      throw_start_r  <= 1'b0;
      aim_enable_r   <= 1'b0;
      turn_done_tx_r <= 1'b0;
      hit_tx_r       <= 1'b0;
      game_over_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      role_r         <= role_s;
      result_r       <= result_s;
      hp_local_r     <= hp_local_s;
      hp_remote_r    <= hp_remote_s;
      winner_r       <= winner_s;
      throw_start_r  <= fire_s;
      aim_enable_r   <= (state_s == LOCAL_AIM);
      turn_done_tx_r <= (state_r == REPORT);
      hit_tx_r       <= (state_r == REPORT) && result_r;
      game_over_r    <= (state_s == GAME_OVER);
    end
  end

  assign ts.throw_start  = throw_start_r;
  assign ts.aim_enable   = aim_enable_r;
  assign ts.turn_done_tx = turn_done_tx_r;
  assign ts.hit_tx       = hit_tx_r;
  assign ts.hp_local     = hp_local_r;
  assign ts.hp_remote    = hp_remote_r;
  assign ts.game_over    = game_over_r;
  assign ts.winner       = winner_r;

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: a table of local turns, hand-written
// corner sequences and random games checked against a turn-level game model.
module tb_turn_scheduler;
  import variable_pkg::*;

  localparam int AIM_T    = 20;
  localparam int FLIGHT_T = 10;
  localparam int HP0      = 3;

  logic clk60MHz;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  turn_scheduler_if ifc ();

  turn_scheduler #(.AIM_TIMEOUT(AIM_T), .FLIGHT_TIMEOUT(FLIGHT_T), .HP_INIT(HP0)) dut (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .ts       (ifc.slave)
  );

  initial clk60MHz = 1'b0;
  always #5 clk60MHz = ~clk60MHz;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int fire_at;  // cycles in aim before fire (>= AIM_T means never)
    int done_at;  // cycles in flight before throw_done
    bit hit;
    int exp_st;   // throw_start cycle, -1 = none
    int exp_td;   // turn_done_tx cycle
    bit exp_hit;
    int exp_hpr;
  } vec_t;

  vec_t tbl[6];

  task automatic tick;
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs;
    ifc.fire_req         = 1'b0;
    ifc.throw_done       = 1'b0;
    ifc.throw_hit        = 1'b0;
    ifc.remote_turn_done = 1'b0;
    ifc.remote_hit       = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    ifc.current_player = NO_PLAYER;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_throw_start"}, int'(ifc.throw_start), 0);
    check({tag, "_aim_enable"}, int'(ifc.aim_enable), 0);
    check({tag, "_turn_done_tx"}, int'(ifc.turn_done_tx), 0);
    check({tag, "_hit_tx"}, int'(ifc.hit_tx), 0);
    check({tag, "_hp_local"}, int'(ifc.hp_local), HP0);
    check({tag, "_hp_remote"}, int'(ifc.hp_remote), HP0);
    check({tag, "_game_over"}, int'(ifc.game_over), 0);
    check({tag, "_winner"}, int'(ifc.winner), 0);
  endtask

  // Plays one local turn starting on the first LOCAL_AIM cycle (t = 0).
  task automatic local_turn(input int fire_at, input int done_at, input bit hit,
                            output int st_t, output int td_t, output int n_st,
                            output bit hit_seen, output int aim_at_st);
    st_t = -1; td_t = -1; n_st = 0; hit_seen = 1'b0; aim_at_st = -1;
    for (int t = 0; t < 60; t++) begin
      if (ifc.throw_start) begin
        n_st++;
        if (st_t < 0) begin
          st_t = t;
          aim_at_st = int'(ifc.aim_enable);
        end
      end
      if (ifc.turn_done_tx) begin
        td_t = t;
        hit_seen = ifc.hit_tx;
        break;
      end
      ifc.fire_req   = (t == fire_at);
      ifc.throw_done = (st_t >= 0) && (t == st_t + done_at);
      ifc.throw_hit  = hit;
      tick();
    end
    clear_inputs();
    if (td_t < 0) check("local_turn_done_seen", 0, 1);
  endtask

  // Remote turn: report after r cycles; optional ignored fire/throw_done noise.
  task automatic remote_turn(input int r, input bit hit, input bit noise);
    int st_cnt = 0;
    int aim_cnt = 0;
    for (int t = 0; t <= r; t++) begin
      if (ifc.throw_start) st_cnt++;
      if (ifc.aim_enable) aim_cnt++;
      ifc.remote_turn_done = (t == r);
      ifc.remote_hit       = hit;
      ifc.fire_req         = noise && ($urandom_range(0, 1) == 1);
      ifc.throw_done       = noise && ($urandom_range(0, 1) == 1);
      ifc.throw_hit        = 1'b1;
      tick();
    end
    if (ifc.throw_start) st_cnt++;
    clear_inputs();
    check("remote_no_throw_start", st_cnt, 0);
    check("remote_aim_low", aim_cnt, 0);
  endtask

  // Turn-level model of when the local report appears and what it says.
  function automatic int model_td(input int fire_at, input int done_at);
    if (fire_at >= AIM_T) return AIM_T + 1;
    if (done_at < FLIGHT_T) return fire_at + done_at + 3;
    return fire_at + FLIGHT_T + 2;
  endfunction

  function automatic bit model_hit(input int fire_at, input int done_at, input bit hit);
    return (fire_at < AIM_T) && (done_at < FLIGHT_T) && hit;
  endfunction

  initial begin
    int st_t, td_t, n_st, aim_at_st, hp_l, hp_r, role, turns, cnt;
    bit hit_seen, over, local_next;

    tbl[0] = '{5, 3, 1'b1, 6, 11, 1'b1, 2};
    tbl[1] = '{0, 0, 1'b0, 1, 3, 1'b0, 2};
    tbl[2] = '{19, 2, 1'b1, 20, 24, 1'b1, 1};
    tbl[3] = '{25, 0, 1'b1, -1, 21, 1'b0, 1};
    tbl[4] = '{2, 30, 1'b1, 3, 14, 1'b0, 1};
    tbl[5] = '{4, 10, 1'b1, 5, 16, 1'b0, 1};

    rst = 1'b1;
    clear_inputs();
    ifc.current_player = NO_PLAYER;
    tick();
    check_reset_outputs("reset");
    do_reset();

    // Table of local turns in one PLAYER_1 game, remote misses in between.
    ifc.current_player = PLAYER_1;
    tick();
    check("p1_aim_enable", int'(ifc.aim_enable), 1);
    for (int i = 0; i < 6; i++) begin
      local_turn(tbl[i].fire_at, tbl[i].done_at, tbl[i].hit, st_t, td_t, n_st, hit_seen, aim_at_st);
      check($sformatf("tbl%0d_throw_start_t", i), st_t, tbl[i].exp_st);
      check($sformatf("tbl%0d_throw_start_n", i), n_st, (tbl[i].exp_st < 0) ? 0 : 1);
      check($sformatf("tbl%0d_turn_done_t", i), td_t, tbl[i].exp_td);
      check($sformatf("tbl%0d_hit_tx", i), int'(hit_seen), int'(tbl[i].exp_hit));
      check($sformatf("tbl%0d_hp_remote", i), int'(ifc.hp_remote), tbl[i].exp_hpr);
      check($sformatf("tbl%0d_aim_low", i), int'(ifc.aim_enable), 0);
      ifc.current_player = PLAYER_2;
      remote_turn(2, 1'b0, 1'b1);
      check($sformatf("tbl%0d_hp_local", i), int'(ifc.hp_local), 3);
      check($sformatf("tbl%0d_aim_back", i), int'(ifc.aim_enable), 1);
    end

    // rst while the projectile is in flight.
    ifc.current_player = PLAYER_1;
    ifc.fire_req = 1'b1;
    tick();
    ifc.fire_req = 1'b0;
    check("flight_throw_start", int'(ifc.throw_start), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_restart_aim", int'(ifc.aim_enable), 1);

    // PLAYER_2 starts waiting; a remote hit costs one local point.
    do_reset();
    ifc.current_player = PLAYER_2;
    tick();
    check("p2_aim_low", int'(ifc.aim_enable), 0);
    remote_turn(3, 1'b1, 1'b1);
    check("p2_hp_local", int'(ifc.hp_local), 2);
    check("p2_aim_enable", int'(ifc.aim_enable), 1);

    // Three local hits end the game; afterwards everything is frozen.
    do_reset();
    ifc.current_player = PLAYER_1;
    tick();
    for (int k = 0; k < 3; k++) begin
      local_turn(1, 1, 1'b1, st_t, td_t, n_st, hit_seen, aim_at_st);
      check($sformatf("win%0d_hp_remote", k), int'(ifc.hp_remote), 2 - k);
      if (k < 2) remote_turn(1, 1'b0, 1'b0);
    end
    check("win_game_over", int'(ifc.game_over), 1);
    check("win_winner", int'(ifc.winner), int'(PLAYER_1));
    ifc.current_player = PLAYER_2;
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      ifc.fire_req = (t % 2 == 0);
      tick();
      if (ifc.throw_start || ifc.aim_enable) cnt++;
    end
    ifc.fire_req = 1'b0;
    check("over_no_activity", cnt, 0);
    check("over_winner_sticky", int'(ifc.winner), int'(PLAYER_1));
    check("over_game_over_sticky", int'(ifc.game_over), 1);

    // Random games against the turn-level model.
    for (int g = 0; g < 20; g++) begin
      do_reset();
      role = $urandom_range(1, 2);
      ifc.current_player = 2'(role);
      tick();
      hp_l = HP0; hp_r = HP0; over = 1'b0; turns = 0;
      local_next = (role == 1);
      check("rnd_start_aim", int'(ifc.aim_enable), local_next ? 1 : 0);
      while (!over && turns < 40) begin
        if (local_next) begin
          int fa, da;
          bit h, mh;
          fa = $urandom_range(0, AIM_T + 3);
          da = $urandom_range(0, FLIGHT_T + 3);
          if (da == FLIGHT_T - 1) da = FLIGHT_T + 1;
          h = ($urandom_range(0, 1) == 1);
          mh = model_hit(fa, da, h);
          if (mh && hp_r > 0) hp_r--;
          local_turn(fa, da, h, st_t, td_t, n_st, hit_seen, aim_at_st);
          check("rnd_turn_done_t", td_t, model_td(fa, da));
          check("rnd_hit_tx", int'(hit_seen), int'(mh));
          check("rnd_throw_start_n", n_st, (fa < AIM_T) ? 1 : 0);
          if (fa < AIM_T) check("rnd_aim_in_flight", aim_at_st, 0);
          check("rnd_hp_remote", int'(ifc.hp_remote), hp_r);
          over = (hp_r == 0);
        end else begin
          bit h;
          h = ($urandom_range(0, 1) == 1);
          if (h && hp_l > 0) hp_l--;
          remote_turn($urandom_range(0, 6), h, 1'b1);
          check("rnd_hp_local", int'(ifc.hp_local), hp_l);
          over = (hp_l == 0);
          if (!over) check("rnd_aim_after_remote", int'(ifc.aim_enable), 1);
        end
        check("rnd_game_over", int'(ifc.game_over), int'(over));
        local_next = !local_next;
        turns++;
      end
      if (over) begin
        check("rnd_winner", int'(ifc.winner), (hp_r == 0) ? role : 3 - role);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
